bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//  Sequencer for multi-digit BCD addition. Reuses one combinational 4-bit BCD digit adder
//   once per clock, least-significant digit first, carrying between digits in a register.
//  Sits between operand registers (switch/keypad capture) and the 7-segment display path.
//  Uses a start/busy/done handshake and flags non-BCD input digits.
// PARAMETERS
//  DIGITS   4   number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//  clk      in   1          system clock, all logic on rising edge
//  rst_n    in   1          synchronous, active-low reset
//  start    in   1          request; accepted only in IDLE or DONE
//  a        in   4*DIGITS   BCD operand A, digit 0 = a[3:0]; sampled on accept
//  b        in   4*DIGITS   BCD operand B, same layout; sampled on accept
//  cin      in   1          carry into digit 0; sampled on accept
//  busy     out  1          high while digits are being processed (ADD)
//  done     out  1          one-cycle pulse: result valid
//  sum      out  4*DIGITS   BCD result; held from done until next accept
//  cout     out  1          decimal carry out of top digit; held like sum
//  err      out  1          any sampled digit of a or b > 9; held like sum
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0, err=0;
//   counter, carry and shift registers cleared. Reset mid-operation aborts; no done pulse.
//  States: IDLE -> ADD on start; ADD -> ADD while cnt<DIGITS-1; ADD -> DONE when
//   cnt==DIGITS-1; DONE -> ADD on start, else DONE -> IDLE. DONE lasts exactly one cycle.
//  Accept (cycle 0): latch a,b into shift regs, carry<=cin, cnt<=0, err<=0 or flag,
//   sum<=0, cout<=0.
//  ADD, each cycle k=0..DIGITS-1: digit adder takes a_sr[3:0], b_sr[3:0], carry;
//   result digit shifts into sum from MSB side; carry<=digit carry-out; a_sr/b_sr shift
//   right 4; cnt++.
//  Digit rule: bin = a+b+c (5 bit); if bin>9 then digit=(bin+6)[3:0], carry=1,
//   else digit=bin[3:0], carry=0.
//  On last ADD cycle cout<=final carry; done=1 in the next cycle (DONE state).
//  Latency: start accepted at edge N -> done high during cycle N+DIGITS+1.
//  Throughput: back-to-back start in DONE gives one result per DIGITS+1 cycles.
//  start while busy=1: ignored; operands are not re-sampled.
//  err: set at accept if any digit of a or b is 10..15; sticky until next accept.
//   Arithmetic still runs with the digit rule; sum is then not a defined decimal value.
//  busy=1 exactly in ADD; busy and done never high together.
//  cnt width = clog2(DIGITS), min 1; with DIGITS=1 ADD lasts one cycle.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE=2'd0, S_ADD=2'd1, S_DONE=2'd2),
//   BCD_MAX=4'd9, BCD_ADJ=4'd6.
//  One sub-module bcd_digit_add: combinational, ports a[3:0], b[3:0], ci -> s[3:0], co,
//   per the digit rule.
//  Top holds the FSM, digit counter, carry register, operand and result shift registers,
//   and the error check.
// TESTING (DIGITS=4)
//  a=16'h1234, b=16'h5678, cin=0, start 1 cycle -> busy 4 cycles; done at cycle 5;
//   sum=16'h6912, cout=0, err=0.
//  a=16'h9999, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; ripple carry through all digits.
//  a=16'h0000, b=16'h0000, cin=1 -> sum=16'h0001, cout=0; a=16'h9999, b=16'h9999,
//   cin=1 -> sum=16'h9999, cout=1.
//  a=16'h00A0, b=16'h0001 -> err=1 with done; then a valid op clears err=0.
//  start pulsed again at cycles 2 and 3 while busy -> ignored; first result unchanged.
//   start held through DONE -> second op accepted, done again 5 cycles later.
//  rst_n=0 for 1 cycle during ADD (cycle 2) -> all outputs 0 next cycle, no done;
//   state IDLE; next start works normally.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants for the serial BCD adder: FSM encoding and decimal digit limits.
package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Combinational single-digit BCD adder with decimal carry correction.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] bin;
  logic [4:0] adj;

  always_comb begin
    bin = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    adj = bin + {1'b0, BCD_ADJ};
    if (bin > {1'b0, BCD_MAX}) begin
      s  = adj[3:0];
      co = 1'b1;
    end else begin
      s  = bin[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD adder sequencer: one digit per clock, LSD first, with
// start/busy/done handshake and a sticky non-BCD input flag.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [3:0]       dsum;
  logic             dco;
  logic [W-1:0]     sum_nxt;

  // True if any nibble of either operand lies outside 0..9.
  function automatic logic non_bcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > BCD_MAX || y[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  bcd_digit_add u_digit (
    .a  (a_sr[3:0]),
    .b  (b_sr[3:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  // New digit enters at the MSB end so that after DIGITS shifts digit 0 sits at sum[3:0].
  always_comb begin
    sum_nxt          = sum >> 4;
    sum_nxt[W-1 -: 4] = dsum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_ADD;
            busy  <= 1'b1;
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            err   <= non_bcd(a, b);
            sum   <= '0;
            cout  <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_ADD: begin
          sum   <= sum_nxt;
          carry <= dco;
          a_sr  <= a_sr >> 4;
          b_sr  <= b_sr >> 4;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= dco;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed-vector bench for bcd_serial_add_ctrl with DIGITS=4.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        err;

  int n_tests;
  int n_fail;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and wait (bounded) for done; reports cycles to done and busy count.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       output int lat, output int busy_n);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic [15:0] es, input logic ec, input logic ee);
    int lat, bn;
    do_op(ta, tb_, tc, lat, bn);
    check({tag, "_lat"},  lat, 5);
    check({tag, "_busy"}, bn, 4);
    check({tag, "_bd"},   {busy, done}, 2'b01);
    check({tag, "_sum"},  sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_err"},  err, ee);
  endtask

  initial begin
    int lat, bn;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check("rst_outs", {busy, done, sum, cout, err}, '0);
    rst_n = 1'b1;
    tick();

    op_check("basic",  16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    tick();
    check("hold_done", done, 1'b0);
    check("hold_sum",  sum, 16'h6912);
    op_check("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_check("cin",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    op_check("max",    16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    op_check("nonbcd", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b1);
    tick();
    check("err_held", err, 1'b1);
    op_check("errclr", 16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0);
    tick();

    // start while busy is ignored; start held into DONE is accepted
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    tick();                                   // cycle 3
    tick();                                   // cycle 4
    a = 16'h0000; b = 16'h0000; cin = 1'b1;
    check("ign_busy4", busy, 1'b1);
    tick();                                   // cycle 5
    check("ign_done", done, 1'b1);
    check("ign_sum",  sum, 16'h6912);
    tick();                                   // cycle 6, second op in progress
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    lat = 6;
    while (!done && lat < 25) begin
      tick();
      lat++;
    end
    check("b2b_lat",  lat, 10);
    check("b2b_sum",  sum, 16'h0001);
    check("b2b_cout", cout, 1'b0);
    tick(); tick();

    // reset during ADD aborts the operation
    a = 16'h00A0; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    check("pre_err", err, 1'b1);
    tick();                                   // cycle 2
    rst_n = 1'b0;
    tick();                                   // cycle 3
    rst_n = 1'b1;
    check("abort_outs", {busy, done, sum, cout, err}, '0);
    bn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) bn++;
      tick();
    end
    check("abort_quiet", bn, 0);
    op_check("post_rst", 16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
